alu_result_tx: RTL and testbench

Transmit-side counterpart of the UART-to-ALU command interpreter. Captures an 8-bit ALU result on a one-cycle strobe and converts it to two ASCII hex characters, optionally followed by CR LF. It then feeds the characters one at a time to the UART transmitter, using a tx_start / tx_done handshake. It sits between the ALU output and the UART TX block, so the PC receives a printable result.

---
 rtl/alu_result_tx_if.sv | 23 ++
 rtl/alu_result_tx.sv | 119 +++++++++++
 tb/tb_alu_result_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_tx_if.sv
// Handshake bundle between the ALU result source, the result transmitter and the UART TX.
// Ports: result_valid/result (new ALU result), tx_done (UART byte finished),
//        d_out/tx_start (byte request to UART), busy/done/overrun (status).
interface alu_result_tx_if;
    logic       result_valid;
    logic [7:0] result;
    logic       tx_done;
    logic [7:0] d_out;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output result_valid, result, tx_done,
        input  d_out, tx_start, busy, done, overrun
    );

    modport slave (
        input  result_valid, result, tx_done,
        output d_out, tx_start, busy, done, overrun
    );
endinterface

// File: rtl/alu_result_tx.sv
// Converts an 8-bit ALU result into ASCII hex (+ optional CR LF) and feeds the bytes to a UART TX.
// Ports: clk, reset (sync, active-high), bus (slave side of alu_result_tx_if); all outputs registered.
module alu_result_tx #(
    parameter bit SEND_CRLF = 1'b1,
    parameter bit HEX_UPPER = 1'b1
) (
    input logic            clk,
    input logic            reset,
    alu_result_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam logic [1:0] LAST = SEND_CRLF ? 2'd3 : 2'd1;

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [7:0] data, data_n;
    logic [7:0] d_out_q, d_out_n;
    logic       tx_start_q, tx_start_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       overrun_q, overrun_n;

    function automatic logic [7:0] hex(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10)
            c = 8'h30 + {4'h0, n};
        else
            c = (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
        return c;
    endfunction

    function automatic logic [7:0] char_at(input logic [7:0] r, input logic [1:0] i);
        logic [7:0] c;
        unique case (i)
            2'd0:    c = hex(r[7:4]);
            2'd1:    c = hex(r[3:0]);
            2'd2:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            data       <= 8'h00;
            d_out_q    <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            data       <= data_n;
            d_out_q    <= d_out_n;
            tx_start_q <= tx_start_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            overrun_q  <= overrun_n;
        end
    end

    // Next byte and tx_start are computed here and registered, so the
    // request appears in the cycle after the triggering event.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        data_n     = data;
        d_out_n    = d_out_q;
        tx_start_n = 1'b0;
        busy_n     = busy_q;
        done_n     = 1'b0;
        // A strobe during the done cycle is refused just like one while busy.
        overrun_n  = bus.result_valid && (busy_q || done_q);

        unique case (state)
            IDLE: begin
                if (bus.result_valid && !done_q) begin
                    data_n     = bus.result;
                    idx_n      = 2'd0;
                    d_out_n    = char_at(bus.result, 2'd0);
                    tx_start_n = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = SEND;
                end
            end
            SEND: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
                    if (idx < LAST) begin
                        idx_n      = idx + 2'd1;
                        d_out_n    = char_at(data, idx + 2'd1);
                        tx_start_n = 1'b1;
                        state_n    = SEND;
                    end else begin
                        idx_n   = 2'd0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.d_out    = d_out_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: default instance (CRLF, upper) and a no-CRLF lowercase instance.
// Expected byte streams come from an ASCII model of the result; timing is checked cycle-exact.
module tb_alu_result_tx;
    typedef logic [7:0] bq_t[$];

    logic clk;
    logic reset;

    logic       rv[2];
    logic [7:0] res[2];
    logic       tdn[2];

    logic [7:0] dout[2];
    logic       start[2];
    logic       busy[2];
    logic       done[2];
    logic       ovr[2];

    int n_chk  = 0;
    int n_pass = 0;

    int start_cnt[2]  = '{0, 0};
    int ovr_cnt[2]    = '{0, 0};
    int done_cnt[2]   = '{0, 0};
    logic prev_start[2] = '{1'b0, 1'b0};

    alu_result_tx_if bus_a ();
    alu_result_tx_if bus_b ();

    alu_result_tx dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    alu_result_tx #(
        .SEND_CRLF (1'b0),
        .HEX_UPPER (1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_a.result_valid = rv[0];
    assign bus_a.result       = res[0];
    assign bus_a.tx_done      = tdn[0];
    assign bus_b.result_valid = rv[1];
    assign bus_b.result       = res[1];
    assign bus_b.tx_done      = tdn[1];

    assign dout[0]  = bus_a.d_out;
    assign start[0] = bus_a.tx_start;
    assign busy[0]  = bus_a.busy;
    assign done[0]  = bus_a.done;
    assign ovr[0]   = bus_a.overrun;
    assign dout[1]  = bus_b.d_out;
    assign start[1] = bus_b.tx_start;
    assign busy[1]  = bus_b.busy;
    assign done[1]  = bus_b.done;
    assign ovr[1]   = bus_b.overrun;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (start[i] === 1'b1)
                chk("b2b_start", {31'd0, prev_start[i]}, 32'd0);
            prev_start[i] <= start[i];
            start_cnt[i]  <= start_cnt[i] + int'(start[i]);
            ovr_cnt[i]    <= ovr_cnt[i] + int'(ovr[i]);
            done_cnt[i]   <= done_cnt[i] + int'(done[i]);
        end
    end

    function automatic logic [7:0] hex_ascii(input int n, input bit upper);
        if (n < 10)
            return 8'(48 + n);
        return 8'((upper ? 65 : 97) + n - 10);
    endfunction

    // Instance 0 is CRLF+uppercase, instance 1 is bare lowercase.
    function automatic bq_t expect_bytes(input logic [7:0] r, input int s);
        bq_t q;
        q.push_back(hex_ascii(int'(r) / 16, s == 0));
        q.push_back(hex_ascii(int'(r) % 16, s == 0));
        if (s == 0) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap <= 0 picks a random WAIT length per byte; ovr_at names the byte
    // during whose SEND cycle a refused strobe is injected.
    task automatic run_seq(input int s, input logic [7:0] r, input int gap,
                           input bit tdn_in_send, input bit rv_at_done, input int ovr_at);
        bq_t q;
        int  g;
        int  st0;
        int  ov0;
        int  dn0;
        int  ovx;
        q   = expect_bytes(r, s);
        st0 = start_cnt[s];
        ov0 = ovr_cnt[s];
        dn0 = done_cnt[s];
        ovx = 0;
        res[s] = r;
        rv[s]  = 1'b1;
        step();
        rv[s]  = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            chk("tx_start", {31'd0, start[s]}, 32'd1);
            chk("d_out", {24'd0, dout[s]}, {24'd0, q[k]});
            chk("busy", {31'd0, busy[s]}, 32'd1);
            if (tdn_in_send)
                tdn[s] = 1'b1;
            g = (gap > 0) ? gap : int'($urandom_range(6, 1));
            for (int c = 0; c < g; c++) begin
                res[s] = 8'($urandom);
                if (k == ovr_at && c == 0) begin
                    rv[s]  = 1'b1;
                    res[s] = 8'h99;
                    ovx++;
                end
                step();
                rv[s]  = 1'b0;
                tdn[s] = 1'b0;
                chk("wait_start", {31'd0, start[s]}, 32'd0);
                chk("d_hold", {24'd0, dout[s]}, {24'd0, q[k]});
                chk("busy_wait", {31'd0, busy[s]}, 32'd1);
                chk("no_done", {31'd0, done[s]}, 32'd0);
            end
            tdn[s] = 1'b1;
            step();
            tdn[s] = 1'b0;
        end
        chk("done", {31'd0, done[s]}, 32'd1);
        chk("busy_end", {31'd0, busy[s]}, 32'd0);
        chk("start_end", {31'd0, start[s]}, 32'd0);
        if (rv_at_done) begin
            rv[s]  = 1'b1;
            res[s] = 8'($urandom);
            ovx++;
        end
        step();
        rv[s] = 1'b0;
        chk("done_pulse", {31'd0, done[s]}, 32'd0);
        chk("busy_after", {31'd0, busy[s]}, 32'd0);
        chk("start_after", {31'd0, start[s]}, 32'd0);
        chk("ovr_done", {31'd0, ovr[s]}, {31'd0, rv_at_done});
        @(negedge clk);
        #1;
        chk("n_start", start_cnt[s] - st0, q.size());
        chk("n_overrun", ovr_cnt[s] - ov0, ovx);
        chk("n_done", done_cnt[s] - dn0, 1);
    endtask

    initial begin
        int s0;
        int d0;
        int s;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i]  = 1'b0;
            res[i] = 8'h00;
            tdn[i] = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_dout", {24'd0, dout[i]}, 32'd0);
            chk("rst_start", {31'd0, start[i]}, 32'd0);
            chk("rst_busy", {31'd0, busy[i]}, 32'd0);
            chk("rst_done", {31'd0, done[i]}, 32'd0);
            chk("rst_ovr", {31'd0, ovr[i]}, 32'd0);
        end
        reset = 1'b0;
        step();

        run_seq(0, 8'h3C, 5, 1'b0, 1'b0, -1);
        run_seq(1, 8'hAF, 5, 1'b0, 1'b0, -1);
        run_seq(0, 8'h00, 3, 1'b0, 1'b0, -1);
        run_seq(0, 8'hFF, 3, 1'b0, 1'b0, -1);
        run_seq(0, 8'h12, 4, 1'b0, 1'b0, 0);

        tdn[0] = 1'b1;
        step();
        chk("idle_tdn_start", {31'd0, start[0]}, 32'd0);
        step();
        tdn[0] = 1'b0;
        chk("idle_tdn_busy", {31'd0, busy[0]}, 32'd0);
        chk("idle_tdn_done", {31'd0, done[0]}, 32'd0);
        run_seq(0, 8'hB7, 3, 1'b1, 1'b0, -1);
        run_seq(1, 8'h4E, 2, 1'b1, 1'b1, 1);

        s0 = start_cnt[0];
        d0 = done_cnt[0];
        res[0] = 8'h5A;
        rv[0]  = 1'b1;
        step();
        rv[0]  = 1'b0;
        chk("rst_b0", {24'd0, dout[0]}, 32'h35);
        repeat (2) step();
        tdn[0] = 1'b1;
        step();
        tdn[0] = 1'b0;
        chk("rst_b1", {24'd0, dout[0]}, 32'h41);
        chk("rst_b1_start", {31'd0, start[0]}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_dout", {24'd0, dout[0]}, 32'd0);
        chk("mid_rst_start", {31'd0, start[0]}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("mid_rst_done", {31'd0, done[0]}, 32'd0);
        tdn[0] = 1'b1;
        step();
        tdn[0] = 1'b0;
        chk("late_tdn_start", {31'd0, start[0]}, 32'd0);
        chk("late_tdn_busy", {31'd0, busy[0]}, 32'd0);
        step();
        chk("late_tdn_done", {31'd0, done[0]}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_n_done", done_cnt[0] - d0, 0);
        chk("rst_n_start", start_cnt[0] - s0, 2);
        run_seq(0, 8'h07, 2, 1'b0, 1'b0, -1);

        for (int n = 0; n < 24; n++) begin
            s = int'($urandom_range(1, 0));
            run_seq(s, 8'($urandom), 0, 1'($urandom), 1'($urandom),
                    int'($urandom_range(5, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
